// File: rtl/fft_pkg.sv
// fft_pkg: frame geometry defaults and sequencer state encoding
package fft_pkg;
  localparam int N = 8;
  localparam int SIZE = 32;
  localparam int LOG2N = 3;
  typedef enum logic [1:0] {LOAD, RUN, WAIT, UNLOAD} state_e;
endpackage

// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: sample stream, butterfly datapath and result stream bundle
interface fft_sequencer_if #(
  parameter int N = fft_pkg::N,
  parameter int SIZE = fft_pkg::SIZE
);
  logic in_valid;
  logic in_ready;
  logic [SIZE-1:0] in_data;
  logic [SIZE*N-1:0] buf_out;
  logic stage_start;
  logic [1:0] stage_idx;
  logic stage_done;
  logic [SIZE*N-1:0] res_in;
  logic out_valid;
  logic out_ready;
  logic [SIZE-1:0] out_data;
  logic out_last;
  logic busy;
  modport master (
    input in_valid, in_data, stage_done, res_in, out_ready,
    output in_ready, buf_out, stage_start, stage_idx, out_valid, out_data, out_last, busy
  );
  modport slave (
    output in_valid, in_data, stage_done, res_in, out_ready,
    input in_ready, buf_out, stage_start, stage_idx, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bit_reverse_mapper.sv
// bit_reverse_mapper: slot i of the output carries input slot bitrev(i)
module bit_reverse_mapper #(
  parameter int N = 8,
  parameter int SIZE = 32
) (
  input  logic [SIZE*N-1:0] din_i,
  output logic [SIZE*N-1:0] dout_o
);
  localparam int W = $clog2(N);
  function automatic int brev(input int i);
    int r;
    r = 0;
    for (int b = 0; b < W; b++) r = r | (((i >> b) & 1) << (W - 1 - b));
    return r;
  endfunction
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign dout_o[i*SIZE +: SIZE] = din_i[brev(i)*SIZE +: SIZE];
  end
endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: loads a frame, steps the butterfly stages, then streams results out
module fft_sequencer #(
  parameter int N = fft_pkg::N,
  parameter int SIZE = fft_pkg::SIZE,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input logic clk,
  input logic rst,
  fft_sequencer_if.master bus
);
  import fft_pkg::*;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
  localparam logic [1:0] STAGE_LAST = 2'(LOG2N - 1);
  state_e state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [1:0] stage_q, stage_d;
  logic [SIZE*N-1:0] samp_q, samp_d, res_q, res_d, rev_w;
  logic cnt_last;
  bit_reverse_mapper #(.N(N), .SIZE(SIZE)) u_brev (.din_i(samp_q), .dout_o(rev_w));
  assign cnt_last = cnt_q == CNT_LAST;
  assign bus.buf_out = rev_w;
  assign bus.in_ready = state_q == LOAD;
  assign bus.busy = state_q != LOAD;
  assign bus.stage_start = state_q == RUN;
  assign bus.stage_idx = stage_q;
  assign bus.out_valid = state_q == UNLOAD;
  assign bus.out_data = res_q[cnt_q*SIZE +: SIZE];
  assign bus.out_last = (state_q == UNLOAD) && cnt_last;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stage_d = stage_q;
    samp_d = samp_q;
    res_d = res_q;
    case (state_q)
      LOAD: if (bus.in_valid) begin
        samp_d[cnt_q*SIZE +: SIZE] = bus.in_data;
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        state_d = cnt_last ? RUN : LOAD;
      end
      RUN: state_d = WAIT;
      WAIT: if (bus.stage_done) begin
        stage_d = stage_q == STAGE_LAST ? '0 : stage_q + 1'b1;
        state_d = stage_q == STAGE_LAST ? UNLOAD : RUN;
        res_d = stage_q == STAGE_LAST ? bus.res_in : res_q;
      end
      UNLOAD: if (bus.out_ready) begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        state_d = cnt_last ? LOAD : UNLOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q <= '0;
      stage_q <= '0;
      samp_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stage_q <= stage_d;
      samp_q <= samp_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed frames with random data checked against a frame-level model
module tb_fft_sequencer;
  localparam int N = 8;
  localparam int SIZE = 32;
  localparam int LOG2N = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_sequencer_if #(.N(N), .SIZE(SIZE)) bus ();
  fft_sequencer #(.N(N), .SIZE(SIZE), .LOG2N(LOG2N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  int starts = 0;
  int lat = 0;
  int base;
  logic [SIZE-1:0] smp [N];
  logic [SIZE-1:0] res [N];
  always @(posedge clk) if (!rst && bus.stage_start === 1'b1) starts <= starts + 1;
  function automatic int brev(input int i);
    int r;
    r = 0;
    for (int b = 0; b < LOG2N; b++) r = r | (((i >> b) & 1) << (LOG2N - 1 - b));
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
    lat++;
  endtask
  task automatic reset_checks;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_stage_start", bus.stage_start, 0);
    chk("rst_stage_idx", bus.stage_idx, 0);
    chk("rst_out_data", bus.out_data, 0);
    for (int i = 0; i < N; i++) chk("rst_buf", bus.buf_out[i*SIZE +: SIZE], 0);
  endtask
  task automatic check_buf(input string tag);
    for (int i = 0; i < N; i++) chk(tag, bus.buf_out[i*SIZE +: SIZE], smp[brev(i)]);
  endtask
  task automatic load(input bit fixed, input bit gaps, input bit glitch);
    int i = 0;
    for (int k = 0; k < N; k++) smp[k] = fixed ? SIZE'(k) : SIZE'($urandom);
    while (i < N) begin
      logic v;
      v = gaps ? 1'($urandom % 2) : 1'b1;
      bus.in_valid = v;
      bus.in_data = v ? smp[i] : SIZE'($urandom);
      bus.stage_done = glitch ? 1'($urandom % 2) : 1'b0;
      chk("load_in_ready", bus.in_ready, 1);
      chk("load_busy", bus.busy, 0);
      chk("load_no_start", bus.stage_start, 0);
      step;
      if (v) i++;
    end
    bus.in_valid = 1'b0;
    bus.stage_done = 1'b0;
    lat = 1;
    chk("busy_rise", bus.busy, 1);
    chk("run_in_ready", bus.in_ready, 0);
    check_buf("buf_rev");
  endtask
  task automatic stages(input int d, input bit glitch);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEAD_BEEF;
    for (int s = 0; s < LOG2N; s++) begin
      int b = 0;
      while (bus.stage_start !== 1'b1 && b < 20) begin
        step;
        b++;
      end
      chk("stage_start_seen", bus.stage_start, 1);
      chk("stage_idx", bus.stage_idx, s);
      bus.stage_done = glitch;
      step;
      bus.stage_done = 1'b0;
      for (int j = 1; j < d; j++) begin
        chk("wait_no_start", bus.stage_start, 0);
        step;
      end
      chk("wait_no_start", bus.stage_start, 0);
      if (s == LOG2N - 1) for (int k = 0; k < N; k++) bus.res_in[k*SIZE +: SIZE] = res[k];
      bus.stage_done = 1'b1;
      step;
      bus.stage_done = 1'b0;
      bus.res_in = {N{32'h5A5A_A5A5}};
    end
    bus.in_valid = 1'b0;
    chk("out_valid_rise", bus.out_valid, 1);
    check_buf("buf_hold");
  endtask
  task automatic unload(input bit toggle);
    int k = 0;
    int c = 0;
    while (k < N && c < 100) begin
      bus.out_ready = toggle ? (c % 3 == 0) : 1'b1;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, res[k]);
      chk("out_last", bus.out_last, k == N - 1);
      if (bus.out_ready) k++;
      step;
      c++;
    end
    bus.out_ready = 1'b0;
    chk("unload_count", k, N);
    if (!toggle) chk("unload_cycles", c, N);
    chk("back_in_ready", bus.in_ready, 1);
    chk("back_busy", bus.busy, 0);
    chk("back_out_valid", bus.out_valid, 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.stage_done = 1'b0;
    bus.res_in = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    step;
    step;
    reset_checks;
    rst = 1'b0;
    base = starts;
    load(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) res[k] = SIZE'(100 + k);
    stages(3, 1'b1);
    unload(1'b0);
    chk("start_count_f1", starts - base, LOG2N);
    base = starts;
    load(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < N; k++) res[k] = SIZE'($urandom);
    stages(1, 1'b0);
    chk("latency", lat, 2 * LOG2N + 1);
    unload(1'b1);
    chk("start_count_f2", starts - base, LOG2N);
    load(1'b0, 1'b0, 1'b0);
    chk("f3_start0", bus.stage_start, 1);
    step;
    bus.stage_done = 1'b1;
    step;
    bus.stage_done = 1'b0;
    chk("f3_stage1_start", bus.stage_start, 1);
    chk("f3_stage1_idx", bus.stage_idx, 1);
    step;
    chk("f3_wait1", bus.stage_start, 0);
    rst = 1'b1;
    step;
    reset_checks;
    rst = 1'b0;
    base = starts;
    load(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) res[k] = SIZE'($urandom);
    stages(2, 1'b0);
    unload(1'b0);
    chk("start_count_f4", starts - base, LOG2N);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter N, default 8: FFT points per frame (power of 2).
REQ-002 Parameter SIZE, default 32: bits per sample.
REQ-003 Parameter LOG2N, default 3: number of butterfly stages, equal to log2(N).
REQ-004 Clock and reset SHALL be: one clock, `clk`; reset `rst`, synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  upstream sample valid.
REQ-008 in_ready  output  1  sequencer accepts a sample.
REQ-009 in_data  input  SIZE  sample, natural index order.
REQ-010 buf_out  output  SIZE*N  frame in bit-reversed order, slot i at [i*SIZE +: SIZE], feeding the butterfly datapath.
REQ-011 stage_start  output  1  one-cycle pulse that starts one butterfly stage.
REQ-012 stage_idx  output  2  index of the current stage, 0..LOG2N-1.
REQ-013 stage_done  input  1  datapath has completed the current stage.
REQ-014 res_in  input  SIZE*N  datapath result bus, slot k at [k*SIZE +: SIZE].
REQ-015 out_valid  output  1  result sample valid.
REQ-016 out_ready  input  1  downstream accepts the sample.
REQ-017 out_data  output  SIZE  result sample k.
REQ-018 out_last  output  1  high with the sample for k = N-1.
REQ-019 busy  output  1  high in every state other than LOAD.

Function
REQ-020 FSM states SHALL be LOAD, RUN, WAIT and UNLOAD; reset SHALL enter LOAD.
REQ-021 LOAD behaviour:
- in_ready SHALL be 1.
- Each in_valid&&in_ready cycle SHALL write in_data to sample buffer slot cnt and increment cnt.
- The handshake at cnt == N-1 SHALL clear cnt and move the FSM to RUN on the next cycle.
REQ-022 in_ready SHALL be 0 in RUN, WAIT and UNLOAD; in_valid SHALL be ignored in those states.
REQ-023 buf_out SHALL be the sample buffer passed through the bit-reverse mapping (slot i = sample bitrev(i)), purely combinationally; it SHALL hold stable from leaving LOAD until the next LOAD write.
REQ-024 RUN behaviour: stage_start SHALL be 1 for exactly one cycle with the current stage_idx; the next state SHALL be WAIT.
REQ-025 WAIT behaviour on stage_done = 1:
- If stage_idx < LOG2N-1: increment stage_idx and go to RUN.
- Otherwise: capture res_in into the result register, clear stage_idx, and go to UNLOAD.
REQ-026 stage_done SHALL be ignored in LOAD, RUN and UNLOAD, including a stage_done in the same cycle as stage_start.
REQ-027 Minimum latency, last load handshake to first out_valid, SHALL be 2*LOG2N+1 cycles when stage_done arrives on the first WAIT cycle of every stage.
REQ-028 UNLOAD behaviour:
- out_valid SHALL be 1.
- out_data SHALL be result slot cnt.
- out_last SHALL be (cnt == N-1).
- Each out_valid&&out_ready cycle SHALL increment cnt.
- The handshake with out_last SHALL clear cnt and return the FSM to LOAD.
REQ-029 While out_ready = 0, out_data and out_last SHALL hold stable; out_valid SHALL NOT deassert before the handshake.
REQ-030 cnt SHALL be log2(N) bits wide and wrap only via the explicit clears above; no arithmetic is performed on sample data.

Reset
REQ-031 On rst, the following SHALL clear on the same edge, from any state including mid-frame:
- state to LOAD, cnt to 0, stage_idx to 0;
- stage_start, out_valid and out_last to 0;
- busy to 0, in_ready to 1;
- sample buffer and result register to 0.
REQ-032 A frame that is partially loaded, mid-stage or mid-unload SHALL be discarded on reset; the first post-reset in_data SHALL become sample 0.

Structure
REQ-033 Package fft_pkg SHALL hold the N, SIZE and LOG2N defaults and the FSM state enumeration.
REQ-034 The bit-reverse mapping SHALL be the existing bit_reverse_mapper instantiated with #(N,SIZE); no other sub-module is used.

Verification
REQ-035 Load samples 0..7 with in_valid held high -> buf_out slots read 0,4,2,6,1,5,3,7, and busy rises the cycle after the 8th handshake.
REQ-036 Answer stage_done 3 cycles after each stage_start -> exactly 3 stage_start pulses with stage_idx 0,1,2, then out_valid rises.
REQ-037 Drive res_in slots = 100+k with out_ready held high -> out_data 100..107 on consecutive cycles, out_last only with 107, in_ready = 1 the next cycle.
REQ-038 Toggle out_ready 1,0,0,1,... -> no sample dropped or duplicated, and out_data is stable while out_ready = 0.
REQ-039 Pulse stage_done during LOAD and during RUN -> no state change and no extra stage_start.
REQ-040 Assert rst during WAIT of stage 1, then load a new frame -> state is LOAD, all outputs take their reset values, and the next frame sequences from stage 0.
